// File: rtl/regfile_wb_arbiter.sv
// Two-lane write-back queue feeding a single register file write port, with
// youngest-match forwarding over pending entries. Ready depends on registered count only.
module regfile_wb_arbiter #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wb0_valid,
  output logic          wb0_ready,
  input  logic [AW-1:0] wb0_addr,
  input  logic [DW-1:0] wb0_data,
  input  logic          wb1_valid,
  output logic          wb1_ready,
  input  logic [AW-1:0] wb1_addr,
  input  logic [DW-1:0] wb1_data,
  output logic          rf_we,
  output logic [AW-1:0] rf_wa,
  output logic [DW-1:0] rf_wd,
  input  logic [AW-1:0] fwd_ra1,
  output logic          fwd_hit1,
  output logic [DW-1:0] fwd_data1,
  input  logic [AW-1:0] fwd_ra2,
  output logic          fwd_hit2,
  output logic [DW-1:0] fwd_data2,
  output logic          idle
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [AW-1:0]    ent_addr [DEPTH];
  logic [DW-1:0]    ent_data [DEPTH];
  logic [DEPTH-1:0] ent_vld;
  logic [PW-1:0]    wptr, rptr, wptr1, fidx;
  logic [CW-1:0]    count;
  logic             push0, push1, pop;

  assign wb0_ready = count < CW'(DEPTH);
  assign wb1_ready = count <= CW'(DEPTH - 2);

  // x0 writes are accepted but dropped here
  assign push0 = wb0_valid && wb0_ready && (wb0_addr != '0);
  assign push1 = wb1_valid && wb1_ready && (wb1_addr != '0);
  assign pop   = count != '0;
  assign wptr1 = wptr + PW'(push0);

  assign rf_we = pop;
  assign rf_wa = ent_addr[rptr];
  assign rf_wd = ent_data[rptr];
  assign idle  = count == '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= '0;
      wptr    <= '0;
      rptr    <= '0;
      ent_vld <= '0;
    end else begin
      if (pop) begin
        ent_vld[rptr] <= 1'b0;
        rptr          <= rptr + 1'b1;
      end
      if (push0) begin
        ent_vld[wptr]  <= 1'b1;
        ent_addr[wptr] <= wb0_addr;
        ent_data[wptr] <= wb0_data;
      end
      if (push1) begin
        ent_vld[wptr1]  <= 1'b1;
        ent_addr[wptr1] <= wb1_addr;
        ent_data[wptr1] <= wb1_data;
      end
      wptr  <= wptr + PW'(push0) + PW'(push1);
      count <= count + CW'(push0) + CW'(push1) - CW'(pop);
    end
  end

  // Walk oldest to youngest so the last match seen is the youngest pending write.
  always_comb begin
    fwd_hit1  = 1'b0;
    fwd_data1 = '0;
    fwd_hit2  = 1'b0;
    fwd_data2 = '0;
    fidx      = rptr;
    for (int i = 0; i < DEPTH; i++) begin
      fidx = rptr + PW'(i);
      if (ent_vld[fidx] && (fwd_ra1 != '0) && (ent_addr[fidx] == fwd_ra1)) begin
        fwd_hit1  = 1'b1;
        fwd_data1 = ent_data[fidx];
      end
      if (ent_vld[fidx] && (fwd_ra2 != '0) && (ent_addr[fidx] == fwd_ra2)) begin
        fwd_hit2  = 1'b1;
        fwd_data2 = ent_data[fidx];
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with an in-order scoreboard of pending writes.
module tb_regfile_wb_arbiter;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb0_valid, wb1_valid;
  logic        wb0_ready, wb1_ready;
  logic [4:0]  wb0_addr, wb1_addr;
  logic [31:0] wb0_data, wb1_data;
  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;
  logic [4:0]  fwd_ra1, fwd_ra2;
  logic        fwd_hit1, fwd_hit2;
  logic [31:0] fwd_data1, fwd_data2;
  logic        idle;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  ent_t q[$];
  int   total = 0;
  int   bad = 0;
  bit   chk_en = 1'b0;

  regfile_wb_arbiter #(.DEPTH(DEPTH), .AW(5), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .wb0_valid(wb0_valid), .wb0_ready(wb0_ready), .wb0_addr(wb0_addr), .wb0_data(wb0_data),
    .wb1_valid(wb1_valid), .wb1_ready(wb1_ready), .wb1_addr(wb1_addr), .wb1_data(wb1_data),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
    .fwd_ra1(fwd_ra1), .fwd_hit1(fwd_hit1), .fwd_data1(fwd_data1),
    .fwd_ra2(fwd_ra2), .fwd_hit2(fwd_hit2), .fwd_data2(fwd_data2),
    .idle(idle)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [32:0] fwd_model(input logic [4:0] ra);
    logic [32:0] r;
    r = '0;
    if (ra != 5'd0)
      foreach (q[i]) if (q[i].a == ra) r = {1'b1, q[i].d};
    return r;
  endfunction

  // One clock: check outputs at negedge against the scoreboard, then advance the model at posedge.
  task automatic step(output bit f0, output bit f1);
    logic [32:0] m1, m2;
    @(negedge clk);
    if (chk_en) begin
      chk("rf_we", 64'(rf_we), 64'(q.size() != 0));
      if (q.size() != 0) begin
        chk("rf_wa", 64'(rf_wa), 64'(q[0].a));
        chk("rf_wd", 64'(rf_wd), 64'(q[0].d));
      end
      chk("wb0_ready", 64'(wb0_ready), 64'(q.size() < DEPTH));
      chk("wb1_ready", 64'(wb1_ready), 64'(q.size() <= DEPTH - 2));
      chk("idle", 64'(idle), 64'(q.size() == 0));
      m1 = fwd_model(fwd_ra1);
      m2 = fwd_model(fwd_ra2);
      chk("fwd1", 64'({fwd_hit1, fwd_data1}), 64'(m1));
      chk("fwd2", 64'({fwd_hit2, fwd_data2}), 64'(m2));
    end
    f0 = wb0_valid && (q.size() < DEPTH) && !rst;
    f1 = wb1_valid && (q.size() <= DEPTH - 2) && !rst;
    @(posedge clk);
    if (rst) q.delete();
    else begin
      if (q.size() != 0) void'(q.pop_front());
      if (f0 && wb0_addr != 5'd0) q.push_back('{wb0_addr, wb0_data});
      if (f1 && wb1_addr != 5'd0) q.push_back('{wb1_addr, wb1_data});
    end
    #1;
  endtask

  task automatic idle_inputs();
    wb0_valid = 1'b0; wb1_valid = 1'b0;
    wb0_addr = '0; wb1_addr = '0; wb0_data = '0; wb1_data = '0;
  endtask

  initial begin
    bit f0, f1;
    int n, guard;
    idle_inputs();
    fwd_ra1 = 5'd3; fwd_ra2 = 5'd7;
    rst = 1'b1;
    step(f0, f1);
    step(f0, f1);
    rst = 1'b0;
    chk_en = 1'b1;
    chk("rst_idle", 64'(idle), 64'd1);
    chk("rst_we", 64'(rf_we), 64'd0);
    step(f0, f1);

    // single write
    fwd_ra1 = 5'd5;
    wb0_valid = 1'b1; wb0_addr = 5'd5; wb0_data = 32'h1FD961AB;
    step(f0, f1);
    idle_inputs();
    chk("single_we", 64'(rf_we), 64'd1);
    chk("single_wa", 64'(rf_wa), 64'd5);
    chk("single_wd", 64'(rf_wd), 64'h1FD961AB);
    step(f0, f1);
    chk("single_after_we", 64'(rf_we), 64'd0);
    chk("single_after_idle", 64'(idle), 64'd1);

    // dual issue to the same register
    fwd_ra1 = 5'd3;
    wb0_valid = 1'b1; wb0_addr = 5'd3; wb0_data = 32'h02345432;
    wb1_valid = 1'b1; wb1_addr = 5'd3; wb1_data = 32'hF7421035;
    step(f0, f1);
    idle_inputs();
    chk("dual_first_wd", 64'(rf_wd), 64'h02345432);
    chk("dual_fwd_both", 64'({fwd_hit1, fwd_data1}), 64'h1F7421035);
    step(f0, f1);
    chk("dual_second_wd", 64'(rf_wd), 64'hF7421035);
    chk("dual_fwd_one", 64'({fwd_hit1, fwd_data1}), 64'h1F7421035);
    step(f0, f1);
    step(f0, f1);

    // x0 filter
    fwd_ra1 = 5'd0; fwd_ra2 = 5'd7;
    wb0_valid = 1'b1; wb0_addr = 5'd0; wb0_data = 32'hDEAD;
    wb1_valid = 1'b1; wb1_addr = 5'd7; wb1_data = 32'hA;
    step(f0, f1);
    idle_inputs();
    chk("x0_wa", 64'(rf_wa), 64'd7);
    chk("x0_wd", 64'(rf_wd), 64'hA);
    chk("x0_fwd_zero", 64'({fwd_hit1, fwd_data1}), 64'd0);
    step(f0, f1);
    chk("x0_single", 64'(idle), 64'd1);

    // fill with dual pushes; values 1..12 must drain in order across wrap
    fwd_ra1 = 5'd9; fwd_ra2 = 5'd12;
    n = 1; guard = 0;
    while (n <= 12 && guard < 60) begin
      wb0_valid = 1'b1; wb0_addr = 5'(n); wb0_data = 32'(n);
      wb1_valid = (n + 1 <= 12); wb1_addr = 5'(n + 1); wb1_data = 32'(n + 1);
      step(f0, f1);
      n = n + int'(f0) + int'(f1 && wb1_valid);
      guard++;
    end
    chk("fill_done", 64'(n > 12), 64'd1);
    idle_inputs();
    guard = 0;
    while (q.size() != 0 && guard < 20) begin
      step(f0, f1);
      guard++;
    end
    chk("fill_drained", 64'(idle), 64'd1);

    // reset mid-drain
    fwd_ra1 = 5'd20; fwd_ra2 = 5'd21;
    wb0_valid = 1'b1; wb0_addr = 5'd20; wb0_data = 32'h20;
    wb1_valid = 1'b1; wb1_addr = 5'd21; wb1_data = 32'h21;
    step(f0, f1);
    wb0_addr = 5'd22; wb0_data = 32'h22; wb1_addr = 5'd20; wb1_data = 32'h120;
    step(f0, f1);
    idle_inputs();
    chk("pre_rst_busy", 64'(idle), 64'd0);
    rst = 1'b1;
    step(f0, f1);
    rst = 1'b0;
    chk("rst_mid_we", 64'(rf_we), 64'd0);
    chk("rst_mid_idle", 64'(idle), 64'd1);
    chk("rst_mid_hit1", 64'(fwd_hit1), 64'd0);
    chk("rst_mid_hit2", 64'(fwd_hit2), 64'd0);
    repeat (4) step(f0, f1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
